// File: rtl/common.sv
// Shared definitions for the execute/memory datapath: operand width, LSU state and
// fault encodings, RV32I load/store funct3 values and lane helpers.
package common;

    localparam int unsigned OPERAND_WIDTH = 32;
    localparam int unsigned DATA_WIDTH    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_ILLEGAL  = 2'b10,
        FLT_TIMEOUT  = 2'b11
    } lsu_fault_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte enables from access size (funct3[1:0]) and byte offset within the word.
    function automatic logic [3:0] lsu_byte_en(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            2'b00:   return 4'b0001 << offset;
            2'b01:   return 4'b0011 << offset;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the store operand across all lanes so any enabled lane sees its data.
    function automatic logic [DATA_WIDTH-1:0] lsu_lane_data(input logic [1:0] size,
                                                            input logic [DATA_WIDTH-1:0] wdata);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the data memory (slave).
interface load_store_unit_if
    import common::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  mem_req;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Moves the addressed byte/halfword of a read word down to bit 0 and sign- or
// zero-extends it according to the load funct3.
module lsu_load_align
    import common::*;
(
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]            offset_i,
    input  logic [2:0]            funct3_i,
    output logic [DATA_WIDTH-1:0] data_c_o
);
    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        shifted  = rdata_i >> {offset_i, 3'b000};
        data_c_o = shifted;
        case (funct3_i)
            F3_B:    data_c_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data_c_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   data_c_o = {24'b0, shifted[7:0]};
            F3_HU:   data_c_o = {16'b0, shifted[15:0]};
            default: data_c_o = shifted;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: decodes and checks requests, drives a variable-latency
// word-addressed memory with timeout, and returns aligned load data or a fault.
module load_store_unit
    import common::*;
#(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 15
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic                     req_is_load,
    input  logic                     req_is_store,
    input  logic [2:0]               req_funct3,
    input  logic [OPERAND_WIDTH-1:0] req_addr,
    input  logic [OPERAND_WIDTH-1:0] req_wdata,
    output logic                     stall,
    output logic                     resp_valid,
    output logic                     resp_fault,
    output logic [1:0]               resp_fault_code,
    output logic [DATA_WIDTH-1:0]    load_data,
    load_store_unit_if.master        mem
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    lsu_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            offset_q, offset_d;
    logic                  is_store_q, is_store_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_fault_q, resp_fault_d;
    lsu_fault_t            resp_code_q, resp_code_d;
    logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic                  req_take_c;
    logic                  f3_legal_c;
    lsu_fault_t            req_fault_c;
    logic [DATA_WIDTH-1:0] aligned_c;
    logic                  addr_unused;

    // Only the word-address bits reach memory; the rest of the ALU result is dropped.
    assign addr_unused = ^req_addr[OPERAND_WIDTH-1:ADDR_WIDTH+2];

    lsu_load_align u_align (
        .rdata_i  (mem.mem_rdata),
        .offset_i (offset_q),
        .funct3_i (funct3_q),
        .data_c_o (aligned_c)
    );

    // Request classification; illegal encodings take priority over misalignment.
    always_comb begin
        req_take_c  = req_valid && (req_is_load || req_is_store);
        f3_legal_c  = 1'b0;
        req_fault_c = FLT_NONE;
        case (req_funct3)
            F3_B, F3_H, F3_W: f3_legal_c = 1'b1;
            F3_BU, F3_HU:     f3_legal_c = req_is_load;
            default:          f3_legal_c = 1'b0;
        endcase
        if ((req_is_load && req_is_store) || !f3_legal_c) begin
            req_fault_c = FLT_ILLEGAL;
        end else if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                     (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)) begin
            req_fault_c = FLT_MISALIGN;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        funct3_d     = funct3_q;
        offset_d     = offset_q;
        is_store_d   = is_store_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        resp_valid_d = 1'b0;
        resp_fault_d = 1'b0;
        resp_code_d  = FLT_NONE;
        load_data_d  = '0;
        stall        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_take_c) begin
                    stall = 1'b1;
                    if (req_fault_c != FLT_NONE) begin
                        state_d      = ERR;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                        resp_code_d  = req_fault_c;
                    end else begin
                        state_d     = BUSY;
                        cnt_d       = '0;
                        funct3_d    = req_funct3;
                        offset_d    = req_addr[1:0];
                        is_store_d  = req_is_store;
                        mem_be_d    = lsu_byte_en(req_funct3[1:0], req_addr[1:0]);
                        mem_addr_d  = req_addr[ADDR_WIDTH+1:2];
                        mem_wdata_d = lsu_lane_data(req_funct3[1:0], req_wdata);
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_is_store;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                // A ready on the last allowed cycle still completes the access.
                if (mem.mem_ready) begin
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                    load_data_d  = is_store_q ? '0 : aligned_c;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = ERR;
                    resp_valid_d = 1'b1;
                    resp_fault_d = 1'b1;
                    resp_code_d  = FLT_TIMEOUT;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    mem_req_d = 1'b1;
                    mem_we_d  = is_store_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            funct3_q     <= '0;
            offset_q     <= '0;
            is_store_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_code_q  <= FLT_NONE;
            load_data_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            funct3_q     <= funct3_d;
            offset_q     <= offset_d;
            is_store_q   <= is_store_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            resp_code_q  <= resp_code_d;
            load_data_q  <= load_data_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign resp_valid      = resp_valid_q;
    assign resp_fault      = resp_fault_q;
    assign resp_fault_code = resp_code_q;
    assign load_data       = load_data_q;
    assign mem.mem_req     = mem_req_q;
    assign mem.mem_we      = mem_we_q;
    assign mem.mem_be      = mem_be_q;
    assign mem.mem_addr    = mem_addr_q;
    assign mem.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic, checked every cycle
// against a byte-level reference model of RV32I load/store behaviour.
module tb_load_store_unit;
    import common::*;

    localparam int unsigned AW = 8;
    localparam int TO = 15;

    logic        clk, rst;
    logic        req_valid, req_is_load, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, resp_valid, resp_fault;
    logic [1:0]  resp_fault_code;
    logic [31:0] load_data;

    load_store_unit_if #(.ADDR_WIDTH(AW)) mem_bus ();

    load_store_unit #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_is_load     (req_is_load),
        .req_is_store    (req_is_store),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .stall           (stall),
        .resp_valid      (resp_valid),
        .resp_fault      (resp_fault),
        .resp_fault_code (resp_fault_code),
        .load_data       (load_data),
        .mem             (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int txn_cyc = 0;

    // Per-cycle expectations written by the driver, consumed by the compare process.
    logic        chk_en = 1'b0;
    logic        e_stall, e_req, e_we, e_rv, e_rf;
    logic [3:0]  e_be;
    logic [7:0]  e_addr;
    logic [31:0] e_wdata, e_ld;
    logic [1:0]  e_code;

    // Most recent observations, for the hand-computed literal checks.
    logic [31:0] last_ld = '0;
    logic [1:0]  last_code = '0;
    logic [3:0]  last_be = '0;
    logic [7:0]  last_addr = '0;
    logic [31:0] last_wdata = '0;
    logic        last_we = 1'b0;
    logic        prev_req = 1'b0;
    int          last_resp_cyc = -1;
    int          last_rise_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 32'(stall), 32'(e_stall));
            check("mem_req", 32'(mem_bus.mem_req), 32'(e_req));
            check("resp_valid", 32'(resp_valid), 32'(e_rv));
            if (e_req) begin
                check("mem_we", 32'(mem_bus.mem_we), 32'(e_we));
                check("mem_be", 32'(mem_bus.mem_be), 32'(e_be));
                check("mem_addr", 32'(mem_bus.mem_addr), 32'(e_addr));
                check("mem_wdata", mem_bus.mem_wdata, e_wdata);
            end
            if (e_rv) begin
                check("resp_fault", 32'(resp_fault), 32'(e_rf));
                check("resp_code", 32'(resp_fault_code), 32'(e_code));
                check("load_data", load_data, e_ld);
            end
        end
        if (resp_valid) begin
            last_ld       <= load_data;
            last_code     <= resp_fault_code;
            last_resp_cyc <= cyc;
        end
        if (mem_bus.mem_req) begin
            last_be    <= mem_bus.mem_be;
            last_addr  <= mem_bus.mem_addr;
            last_wdata <= mem_bus.mem_wdata;
            last_we    <= mem_bus.mem_we;
            if (!prev_req) last_rise_cyc <= cyc;
        end
        prev_req <= mem_bus.mem_req;
    end

    // Reference model: works on byte counts and lane indices rather than shifts/masks.
    function automatic void predict(input logic ld, input logic st, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [31:0] rdata, output logic [1:0] code,
                                    output logic [3:0] be, output logic [7:0] maddr,
                                    output logic [31:0] mwdata, output logic [31:0] ldata);
        int     n, off;
        longint v;
        bit     legal;
        n   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off = int'(addr[1:0]);
        if (ld && st)  legal = 1'b0;
        else if (ld)   legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        else           legal = f3 inside {3'd0, 3'd1, 3'd2};
        code   = !legal ? 2'd2 : ((off % n) != 0) ? 2'd1 : 2'd0;
        be     = '0;
        mwdata = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + n) be[i] = 1'b1;
            mwdata[8*i +: 8] = wdata[8*(i % n) +: 8];
        end
        maddr = 8'(addr >> 2);
        v = 0;
        for (int j = 0; j < n; j++)
            if (off + j < 4) v += longint'(rdata[8*(off+j) +: 8]) << (8*j);
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8*n - 1))) v -= longint'(1) << (8*n);
        ldata = (st || code != 2'd0) ? 32'd0 : 32'(v);
    endfunction

    task automatic garbage();
        req_valid    = 1'($urandom);
        req_is_load  = 1'($urandom);
        req_is_store = 1'($urandom);
        req_funct3   = 3'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
    endtask

    // One request; mem_ready is raised on BUSY cycle wait_n (wait_n >= TO means never).
    task automatic do_txn(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int wait_n);
        logic [1:0]  code;
        logic [3:0]  be;
        logic [7:0]  ma;
        logic [31:0] mw, ldx;
        bit          take;
        predict(ld, st, f3, addr, wdata, rdata, code, be, ma, mw, ldx);
        take = v && (ld || st);

        @(posedge clk); #1;
        txn_cyc = cyc;
        req_valid = v; req_is_load = ld; req_is_store = st;
        req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        mem_bus.mem_ready = 1'($urandom);
        mem_bus.mem_rdata = $urandom;
        e_stall = take; e_req = 1'b0; e_rv = 1'b0;
        chk_en = 1'b1;
        if (!take) return;

        @(posedge clk); #1;
        garbage();
        if (code != 2'd0) begin
            e_stall = 1'b0; e_req = 1'b0; e_rv = 1'b1; e_rf = 1'b1; e_code = code; e_ld = '0;
            return;
        end
        for (int k = 0; k < TO; k++) begin
            if (k > 0) begin @(posedge clk); #1; garbage(); end
            mem_bus.mem_ready = (k == wait_n);
            mem_bus.mem_rdata = (k == wait_n) ? rdata : $urandom;
            e_stall = 1'b1; e_req = 1'b1; e_we = st; e_be = be; e_addr = ma; e_wdata = mw;
            e_rv = 1'b0;
            if (k == wait_n) break;
        end
        @(posedge clk); #1;
        garbage();
        mem_bus.mem_ready = 1'($urandom);
        e_stall = 1'b0; e_req = 1'b0; e_rv = 1'b1;
        if (wait_n < TO) begin
            e_rf = 1'b0; e_code = 2'd0; e_ld = ldx;
        end else begin
            e_rf = 1'b1; e_code = 2'd3; e_ld = '0;
        end
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rst_cyc;
        rst = 1'b1;
        req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0;
        mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_fault", 32'(resp_fault), 32'd0);
        check("rst_resp_code", 32'(resp_fault_code), 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_bus.mem_we), 32'd0);
        check("rst_mem_be", 32'(mem_bus.mem_be), 32'd0);
        check("rst_mem_addr", 32'(mem_bus.mem_addr), 32'd0);
        check("rst_mem_wdata", mem_bus.mem_wdata, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // LB from byte 3 of word 4, sign bit set
        do_txn(1'b1, 1'b1, 1'b0, F3_B, 32'h13, $urandom, 32'h80FF_7F01, 0);
        settle();
        check("lb_data", last_ld, 32'hFFFF_FF80);
        check("lb_be", 32'(last_be), 32'h8);
        check("lb_addr", 32'(last_addr), 32'h04);
        check("lb_latency", 32'(last_resp_cyc - txn_cyc), 32'd2);

        // SH to upper half with three wait cycles
        do_txn(1'b1, 1'b0, 1'b1, F3_H, 32'h22, 32'h1234_ABCD, $urandom, 3);
        settle();
        check("sh_be", 32'(last_be), 32'hC);
        check("sh_wdata", last_wdata, 32'hABCD_ABCD);
        check("sh_we", 32'(last_we), 32'd1);
        check("sh_latency", 32'(last_resp_cyc - last_rise_cyc), 32'd4);
        check("sh_load_data", last_ld, 32'd0);

        // Misaligned LW never reaches memory
        do_txn(1'b1, 1'b1, 1'b0, F3_W, 32'h06, $urandom, $urandom, 0);
        settle();
        check("lw_mis_code", 32'(last_code), 32'd1);
        check("lw_mis_latency", 32'(last_resp_cyc - txn_cyc), 32'd1);
        check("lw_mis_no_req", 32'(last_rise_cyc < txn_cyc), 32'd1);

        do_txn(1'b1, 1'b1, 1'b0, F3_HU, 32'h42, $urandom, 32'hF00D_8001, 1);
        settle();
        check("lhu_data", last_ld, 32'h0000_F00D);

        do_txn(1'b1, 1'b0, 1'b1, 3'b100, 32'h40, $urandom, $urandom, 0);
        settle();
        check("st_f3_illegal", 32'(last_code), 32'd2);

        do_txn(1'b1, 1'b1, 1'b1, F3_W, 32'h40, $urandom, $urandom, 0);
        settle();
        check("both_illegal", 32'(last_code), 32'd2);

        do_txn(1'b1, 1'b0, 1'b0, F3_W, 32'h40, $urandom, $urandom, 0);
        settle();
        check("neither_ignored", 32'(last_resp_cyc < txn_cyc), 32'd1);

        // Timeout, then a normal access, then ready on the final allowed cycle
        do_txn(1'b1, 1'b1, 1'b0, F3_W, 32'h80, $urandom, $urandom, 99);
        settle();
        check("timeout_code", 32'(last_code), 32'd3);
        check("timeout_latency", 32'(last_resp_cyc - last_rise_cyc), 32'd15);
        do_txn(1'b1, 1'b1, 1'b0, F3_W, 32'h84, $urandom, 32'h0BAD_F00D, 0);
        settle();
        check("after_timeout_code", 32'(last_code), 32'd0);
        check("after_timeout_data", last_ld, 32'h0BAD_F00D);
        do_txn(1'b1, 1'b1, 1'b0, F3_W, 32'h88, $urandom, 32'h1357_9BDF, TO - 1);
        settle();
        check("last_cycle_ready_code", 32'(last_code), 32'd0);
        check("last_cycle_ready_data", last_ld, 32'h1357_9BDF);

        // Asynchronous reset in the middle of BUSY
        @(posedge clk); #1;
        req_valid = 1'b1; req_is_load = 1'b1; req_is_store = 1'b0;
        req_funct3 = F3_W; req_addr = 32'h40; req_wdata = '0;
        mem_bus.mem_ready = 1'b0;
        e_stall = 1'b1; e_req = 1'b0; e_rv = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        e_stall = 1'b1; e_req = 1'b1; e_we = 1'b0; e_be = 4'hF; e_addr = 8'h10;
        e_wdata = last_wdata; e_rv = 1'b0;
        chk_en = 1'b0;
        @(posedge clk); #3;
        rst_cyc = cyc;
        rst = 1'b1;
        #1;
        check("midrst_mem_req", 32'(mem_bus.mem_req), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        repeat (2) @(negedge clk);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        do_txn(1'b1, 1'b1, 1'b0, F3_W, 32'h00, $urandom, 32'hDEAD_BEEF, 1);
        settle();
        check("midrst_no_resp", 32'(last_resp_cyc > rst_cyc + 3), 32'd1);
        check("post_rst_lw", last_ld, 32'hDEAD_BEEF);

        // Random traffic
        for (int t = 0; t < 300; t++) begin
            int          r, w, wn;
            logic        v, ld, st;
            logic [2:0]  f3;
            logic [31:0] a;
            r  = $urandom_range(0, 99);
            ld = (r < 45) || (r >= 92);
            st = (r >= 45 && r < 85) || (r >= 92);
            v  = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 9) < 8) begin
                if (ld && !st) begin
                    f3 = 3'($urandom_range(0, 4));
                    if (f3 > 3'd2) f3 = f3 + 3'd1;
                end else begin
                    f3 = 3'($urandom_range(0, 2));
                end
            end else begin
                f3 = 3'($urandom);
            end
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            w  = $urandom_range(0, 9);
            wn = (w < 7) ? $urandom_range(0, 3) : (w == 7) ? TO - 1 :
                 (w == 8) ? TO + $urandom_range(0, 3) : $urandom_range(4, TO - 2);
            do_txn(v, ld, st, f3, a, $urandom, $urandom, wn);
        end
        settle();
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the memory stage's data memory.
- Turns RV32I load/store requests (LB/LH/LW/LBU/LHU, SB/SH/SW) into word-addressed memory accesses with byte enables and lane-replicated store data.
- Handles a variable-latency memory handshake with a timeout, and returns aligned, sign- or zero-extended load data.
- Stalls the pipeline while an access is in flight, and reports misaligned, illegal and timeout faults.

Parameters:
- ADDR_WIDTH, 8: width of the word address driven to data memory.
- TIMEOUT_CYCLES, 15: maximum cycles spent in BUSY without mem_ready before a timeout fault.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  execute stage presents a memory instruction.
- req_is_load  in  1  request is a load.
- req_is_store  in  1  request is a store.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  OPERAND_WIDTH  byte address (ALU result).
- req_wdata  in  OPERAND_WIDTH  store data (rs2 or forwarded value).
- stall  out  1  hold the upstream pipeline.
- resp_valid  out  1  one-cycle completion pulse.
- resp_fault  out  1  completion carries a fault.
- resp_fault_code  out  2  00 none, 01 misaligned, 10 illegal, 11 timeout.
- load_data  out  32  extended load result; 0 for stores and faults.
- mem_req  out  1  memory access request.
- mem_we  out  1  write enable.
- mem_be  out  4  byte enables.
- mem_addr  out  ADDR_WIDTH  word address, req_addr[ADDR_WIDTH+1:2].
- mem_wdata  out  32  lane-replicated store data.
- mem_ready  in  1  memory accepts a write or returns read data this cycle.
- mem_rdata  in  32  read data, valid with mem_ready.

Behaviour:
- Reset: async; state IDLE, counter 0. Every registered output is 0: resp_*, load_data, mem_req, mem_we, mem_be, mem_addr, mem_wdata.
- Reset mid-access: mem_req drops immediately; the access is abandoned with no response.
- FSM has four states: IDLE, BUSY, DONE, ERR.
- IDLE:
  - Accepts a request when req_valid and exactly one of req_is_load / req_is_store is set.
  - req_valid with neither set: ignored.
  - req_valid with both set: illegal fault.
  - Valid funct3 for loads: 000, 001, 010, 100, 101. For stores: 000, 001, 010. Any other value is illegal (code 10).
  - Misaligned (code 01): halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Illegal is checked before misaligned.
  - Faulting request: go to ERR; no memory access is made.
  - Good request: register addr, byte offset, funct3, be and wdata; go to BUSY.
- Byte enables and store data:
  - Byte: be = 0001<<addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Half: be = 0011<<addr[1:0]; wdata = {2{wdata[15:0]}}.
  - Word: be = 1111; wdata unchanged.
  - Loads drive be the same way, but mem_we=0.
- BUSY:
  - mem_req=1 and mem_we=is_store; all mem_* outputs stay stable until mem_ready.
  - On mem_ready: capture mem_rdata, go to DONE.
  - Otherwise the wait counter increments. If the counter equals TIMEOUT_CYCLES-1 and mem_ready is low, go to ERR with code 11.
  - mem_ready in the same cycle as the timeout wins, so the access succeeds.
- DONE:
  - resp_valid=1 for one cycle, resp_fault=0, then return to IDLE.
  - Store: load_data=0.
  - Load: shift the captured word right by 8*offset, then extend: LB sign-extends from bit 7, LH from bit 15; LBU and LHU zero-extend; LW passes through.
- ERR: resp_valid=1, resp_fault=1, code held for one cycle, load_data=0, then return to IDLE.
- stall (combinational) = (state==IDLE && accepted request) || state==BUSY. It is low in DONE and ERR, so the pipeline advances on the response cycle.
- Latency: request in cycle 0; mem_req in cycle 1; with mem_ready in cycle 1, resp_valid in cycle 2. Each wait cycle adds one. Fault responses arrive in cycle 1.
- Requests presented outside IDLE are ignored; upstream is stalled then. Back-to-back requests are accepted in the cycle after DONE or ERR.
- mem_ready while not in BUSY is ignored.

Decomposition:
- Package common gets OPERAND_WIDTH, which already exists there, plus these new definitions:
  - lsu_state_t enum (IDLE, BUSY, DONE, ERR).
  - lsu_fault_t 2-bit enum.
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
- One sub-module, lsu_load_align: combinational shift and sign/zero extension of the read word, from offset and funct3.

Test Plan:
- LB addr 0x13, mem_rdata 0x80FF_7F01, mem_ready in cycle 1 -> mem_be 1000, mem_addr 0x04, resp_valid in cycle 2, load_data 0xFFFF_FF80; stall high in cycles 0-1.
- SH addr 0x22, wdata 0x1234_ABCD, mem_ready after 3 wait cycles -> mem_be 1100, mem_wdata 0xABCD_ABCD, mem_we 1 held stable, resp_valid 4 cycles after mem_req rose, load_data 0.
- LW addr 0x06 -> ERR in cycle 1, resp_fault_code 01, mem_req never asserted.
- LHU with funct3 101 on rdata 0xF00D_8001 at offset 2 -> load_data 0x0000_F00D. Store with funct3 100 -> fault code 10.
- mem_ready held low -> after 15 BUSY cycles, resp_fault_code 11; next request accepted normally. Variant with mem_ready on the final cycle -> success, not a timeout.
- rst asserted mid-BUSY -> mem_req falls asynchronously, no resp_valid; after release, an LW to 0x00 completes normally.
